aes_iter_core: RTL and testbench

AES_ITER_CORE -- requirements
Module: aes_iter_core

---
 rtl/aes_iter_core.sv | 198 +++++++++++++++++++
 tb/tb_aes_iter_core.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_iter_core.sv
// Iterative AES-128 encryptor: one round per clock, on-the-fly key expansion,
// with ECB / CBC / CTR chaining and a valid/ready block interface.
module aes_iter_core #(
    parameter int unsigned CTR_W    = 32,
    parameter logic [1:0]  RST_MODE = 2'b00
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] block_data,
    input  logic [127:0] key,
    input  logic         iv_load,
    input  logic [127:0] iv,
    input  logic [1:0]   mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
    typedef enum logic [1:0] {M_ECB = 2'b00, M_CBC = 2'b01, M_CTR = 2'b10, M_RSV = 2'b11} mode_t;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] base;
        base = {~x, 3'b000};
        return SBOX[base +: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte n of the block sits at bits [127-8n -: 8]; column c holds bytes 4c..4c+3.
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = sbox(s[127 - 8*(4*((c + r) % 4) + r) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            o[127 - 32*c -: 32] = mix_col(s[127 - 32*c -: 32]);
        end
        return o;
    endfunction

    function automatic logic [127:0] key_next(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
        {w0, w1, w2, w3} = rk;
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h000000};
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    state_t       state_q, state_d;
    mode_t        mode_q, mode_d;
    logic [127:0] st_q, st_d;
    logic [127:0] rk_q, rk_d;
    logic [127:0] blk_q, blk_d;
    logic [127:0] chain_q, chain_d;
    logic [127:0] out_q, out_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [3:0]   cnt_q, cnt_d;

    logic [127:0] next_rk, sub_sh, round_out, cipher_in;
    logic         accept;

    assign next_rk   = key_next(rk_q, rcon_q);
    assign sub_sh    = sub_shift(st_q);
    assign round_out = ((cnt_q == 4'd10) ? sub_sh : mix_columns(sub_sh)) ^ next_rk;

    assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == ROUND);
    assign out_data  = out_q;

    always_comb begin
        case (mode_q)
            M_CBC:   cipher_in = block_data ^ chain_q;
            M_CTR:   cipher_in = chain_q;
            default: cipher_in = block_data;
        endcase
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        st_d    = st_q;
        rk_d    = rk_q;
        blk_d   = blk_q;
        chain_d = chain_q;
        out_d   = out_q;
        rcon_d  = rcon_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (!accept && iv_load) begin
                    chain_d = iv;
                    mode_d  = mode_t'(mode);
                end
            end
            ROUND: begin
                st_d   = round_out;
                rk_d   = next_rk;
                rcon_d = xt(rcon_q);
                cnt_d  = cnt_q + 4'd1;
                // Chain advances at cipher completion so a block accepted on the
                // output handshake edge already sees the updated value.
                if (cnt_q == 4'd10) begin
                    state_d = DONE;
                    case (mode_q)
                        M_CBC: begin
                            out_d   = round_out;
                            chain_d = round_out;
                        end
                        M_CTR: begin
                            out_d                = round_out ^ blk_q;
                            chain_d[CTR_W-1:0]   = chain_q[CTR_W-1:0] + 1'b1;
                        end
                        default: out_d = round_out;
                    endcase
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            state_d = ROUND;
            st_d    = cipher_in ^ key;
            rk_d    = key;
            rcon_d  = 8'h01;
            cnt_d   = 4'd1;
            blk_d   = block_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= mode_t'(RST_MODE);
            st_q    <= '0;
            rk_q    <= '0;
            blk_q   <= '0;
            chain_q <= '0;
            out_q   <= '0;
            rcon_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            st_q    <= st_d;
            rk_q    <= rk_d;
            blk_q   <= blk_d;
            chain_q <= chain_d;
            out_q   <= out_d;
            rcon_q  <= rcon_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_aes_iter_core.sv
// Self-checking bench for aes_iter_core: known-answer table, corner sequences,
// and randomized blocks against a behavioural AES/chaining model.
module tb_aes_iter_core;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] block_data;
    logic [127:0] key;
    logic         iv_load;
    logic [127:0] iv;
    logic [1:0]   mode;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    aes_iter_core #(.CTR_W(32), .RST_MODE(2'b10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .block_data (block_data),
        .key        (key),
        .iv_load    (iv_load),
        .iv         (iv),
        .mode       (mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [7:0]   sbox_m [256];
    logic [127:0] m_chain;
    logic [1:0]   m_mode;

    typedef struct {
        logic         do_iv;
        logic [1:0]   md;
        logic [127:0] ivv;
        logic [127:0] k;
        logic [127:0] d;
        logic [127:0] exp;
        int           stall;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic void build_sbox();
        logic [7:0] inv, b;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            b = inv;
            sbox_m[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]], sbox_m[tmp[31:24]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ w[i/4][31 - 8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[4*c + row] = sbox_m[s[4*((c + row) % 4) + row]];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (r < 10) begin
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) s[i] ^= w[4*r + i/4][31 - 8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] model_block(input logic [127:0] k, input logic [127:0] d);
        logic [127:0] r;
        case (m_mode)
            2'b01: begin
                r = aes_ref(k, d ^ m_chain);
                m_chain = r;
            end
            2'b10: begin
                r = aes_ref(k, m_chain) ^ d;
                m_chain[31:0] = m_chain[31:0] + 32'd1;
            end
            default: r = aes_ref(k, d);
        endcase
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic iv_pulse(input logic [1:0] md, input logic [127:0] v);
        iv_load = 1'b1;
        mode    = md;
        iv      = v;
        @(negedge clk);
        iv_load = 1'b0;
        m_mode  = md;
        m_chain = v;
    endtask

    // Issues one block from IDLE, scrambles inputs mid-round, optionally stalls the output.
    task automatic run_block(input logic [127:0] k, input logic [127:0] d, input int stall,
                             output logic [127:0] got, output int lat);
        int w;
        key        = k;
        block_data = d;
        in_valid   = 1'b1;
        out_ready  = 1'b0;
        w = 0;
        while (!in_ready && w < 30) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        iv_load  = 1'b0;
        chk("busy_in_round", busy, 1);
        chk("in_ready_in_round", in_ready, 0);
        key        = rnd128();
        block_data = rnd128();
        iv         = rnd128();
        mode       = 2'($urandom_range(0, 3));
        iv_load    = 1'b1;
        @(negedge clk);
        iv_load = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        got = out_data;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_out_data", out_data, got);
            chk("stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        logic [127:0] got, exp, expa, expb, k, d;
        int lat;
        int cyc;
        logic seen;

        rst_n = 1'b0; in_valid = 1'b0; block_data = '0; key = '0;
        iv_load = 1'b0; iv = '0; mode = 2'b00; out_ready = 1'b0;
        build_sbox();

        vecs[0] = '{1'b1, 2'b00, '0, 128'h000102030405060708090a0b0c0d0e0f,
                    128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0};
        vecs[1] = '{1'b1, 2'b00, '0, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32, 5};
        vecs[2] = '{1'b1, 2'b01, 128'h000102030405060708090a0b0c0d0e0f, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h6bc1bee22e409f96e93d7e117393172a, 128'h7649abac8119b246cee98e9b12e9197d, 0};
        vecs[3] = '{1'b0, 2'b01, '0, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'hae2d8a571e03ac9c9eb76fac45af8e51, 128'h5086cb9b507219ee95db113a917678b2, 2};
        vecs[4] = '{1'b1, 2'b10, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h6bc1bee22e409f96e93d7e117393172a, 128'h874d6191b620e3261bef6864990db6ce, 0};
        vecs[5] = '{1'b0, 2'b10, '0, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'hae2d8a571e03ac9c9eb76fac45af8e51, 128'h9806f66b7970fdff8617187bb9fffdff, 1};
        vecs[6] = '{1'b1, 2'b11, '0, 128'h000102030405060708090a0b0c0d0e0f,
                    128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0};

        repeat (3) @(negedge clk);
        chk("reset_in_ready", in_ready, 1);
        rst_n = 1'b1;
        m_chain = '0;
        m_mode  = 2'b10;
        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_in_ready_after", in_ready, 1);

        // After reset the core runs CTR (reset mode) from a zero counter.
        k = rnd128(); d = rnd128();
        exp = model_block(k, d);
        run_block(k, d, 0, got, lat);
        chk("first_after_reset", got, exp);
        chk("first_latency", 128'(lat), 10);

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].do_iv) iv_pulse(vecs[i].md, vecs[i].ivv);
            void'(model_block(vecs[i].k, vecs[i].d));
            run_block(vecs[i].k, vecs[i].d, vecs[i].stall, got, lat);
            chk($sformatf("kat%0d_data", i), got, vecs[i].exp);
            chk($sformatf("kat%0d_latency", i), 128'(lat), 10);
        end

        // Back-to-back: second block accepted on the first output handshake edge.
        iv_pulse(2'b01, rnd128());
        k = rnd128();
        expa = model_block(k, 128'h11111111222222223333333344444444);
        expb = model_block(k, 128'h5555555566666666777777778888888a);
        key = k; block_data = 128'h11111111222222223333333344444444;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        block_data = 128'h5555555566666666777777778888888a;
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("b2b_first_latency", 128'(cyc), 10);
        chk("b2b_first_data", out_data, expa);
        chk("b2b_in_ready_on_done", in_ready, 1);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                in_valid = 1'b0;
                chk("b2b_busy_after_handshake", busy, 1);
                chk("b2b_valid_dropped", out_valid, 0);
            end
        end while (!out_valid && cyc < 40);
        chk("b2b_spacing", 128'(cyc), 11);
        chk("b2b_second_data", out_data, expb);
        @(negedge clk);
        out_ready = 1'b0;

        // iv_load together with in_valid in IDLE: block wins, iv_load discarded.
        k = rnd128(); d = rnd128();
        exp = model_block(k, d);
        iv_load = 1'b1; iv = rnd128(); mode = 2'b10;
        run_block(k, d, 0, got, lat);
        chk("prio_block", got, exp);
        k = rnd128(); d = rnd128();
        exp = model_block(k, d);
        run_block(k, d, 0, got, lat);
        chk("prio_chain_kept", got, exp);

        // CTR low-word wrap with fixed upper bits.
        iv_pulse(2'b10, {96'h0123456789abcdef01234567, 32'hffffffff});
        for (int i = 0; i < 2; i++) begin
            k = 128'h2b7e151628aed2a6abf7158809cf4f3c; d = rnd128();
            exp = model_block(k, d);
            run_block(k, d, 0, got, lat);
            chk($sformatf("ctr_wrap%0d", i), got, exp);
        end

        // Reset asserted in round 5 aborts the block.
        iv_pulse(2'b01, rnd128());
        key = rnd128(); block_data = rnd128(); in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", out_valid, 0);
        chk("midreset_in_ready", in_ready, 1);
        chk("midreset_busy", busy, 0);
        chk("midreset_out_data", out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_chain = '0;
        m_mode  = 2'b10;
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("midreset_no_output", seen, 0);
        k = rnd128(); d = rnd128();
        exp = model_block(k, d);
        run_block(k, d, 0, got, lat);
        chk("midreset_next_block", got, exp);

        for (int n = 0; n < 40; n++) begin
            if (n == 0 || $urandom_range(0, 3) == 0) begin
                iv = rnd128();
                if ($urandom_range(0, 1) == 1) iv[31:0] = 32'hffffffff - 32'($urandom_range(0, 2));
                iv_pulse(2'($urandom_range(0, 3)), iv);
            end
            k = rnd128(); d = rnd128();
            exp = model_block(k, d);
            run_block(k, d, $urandom_range(0, 3), got, lat);
            chk($sformatf("rand%0d_data", n), got, exp);
            chk($sformatf("rand%0d_latency", n), 128'(lat), 10);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
